// File: rtl/uart_tx_fifo_pkg.sv
// +--------------------------------------------------------------------+
// | uart_tx_fifo_pkg : shared FSM state encoding, framing constants     |
// |   and baud divisor helper. Honours UART_TX_PARITY_EN (8E1 framing).  |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
`default_nettype none

package uart_tx_fifo_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = DATA_BITS + 3;
`else
  localparam int FRAME_BITS = DATA_BITS + 2;
`endif

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_gen.sv
// +--------------------------------------------------------------------+
// | uart_baud_gen : bit-period counter, pulses bit_done on the last      |
// |   clock of every bit; restart re-aligns it to a new frame.           |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
`default_nettype none

module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic bit_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] c_last = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      r_cnt <= '0;
    end else if (r_cnt == c_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign bit_done = (r_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// +--------------------------------------------------------------------+
// | uart_tx_fifo : byte FIFO feeding a baud-timed 8N1 serialiser on TXD. |
// |   Define UART_TX_PARITY_EN for an even-parity bit (8E1 framing).     |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
`default_nettype none

module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int BAUD_RATE   = 115200,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_valid,
  input  logic [7:0]                    wr_data,
  output logic                          wr_ready,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          TXD
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int LVL_W        = PTR_W + 1;
  localparam logic [LVL_W-1:0] c_full_level = LVL_W'(FIFO_DEPTH);
  localparam logic [2:0]       c_last_idx   = 3'(DATA_BITS - 1);

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             r_overflow;
  logic             w_push;
  logic             w_pop;
  logic             w_level_nz;
  logic [7:0]       w_head;

  tx_state_t  r_state;
  tx_state_t  w_state_nxt;
  logic [7:0] r_shift;
  logic [7:0] w_shift_nxt;
  logic [2:0] r_idx;
  logic [2:0] w_idx_nxt;
  logic       r_txd;
  logic       w_txd_nxt;
  logic       w_restart;
  logic       w_bit_done;
`ifdef UART_TX_PARITY_EN
  logic       r_parity;
  logic       w_parity_nxt;
`endif

  // Full is judged from the registered level only, so a pop never frees a slot
  // in the same cycle.
  assign wr_ready   = (r_level != c_full_level);
  assign w_push     = wr_valid && wr_ready;
  assign w_level_nz = (r_level != '0);
  assign w_head     = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= wr_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + LVL_W'(1);
      end else if (w_pop && !w_push) begin
        r_level <= r_level - LVL_W'(1);
      end
      if (wr_valid && !wr_ready) begin
        r_overflow <= 1'b1;
      end
    end
  end

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .reset   (reset),
    .restart (w_restart),
    .bit_done(w_bit_done)
  );

  // TXD is a register: each branch sets the level the line must carry
  // for the state being entered.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_idx_nxt   = r_idx;
    w_txd_nxt   = r_txd;
    w_pop       = 1'b0;
    w_restart   = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_parity_nxt = r_parity;
`endif
    case (r_state)
      IDLE: begin
        w_txd_nxt = 1'b1;
        if (w_level_nz) begin
          w_pop       = 1'b1;
          w_restart   = 1'b1;
          w_shift_nxt = w_head;
          w_state_nxt = START;
          w_txd_nxt   = 1'b0;
`ifdef UART_TX_PARITY_EN
          w_parity_nxt = ^w_head;
`endif
        end
      end
      START: begin
        if (w_bit_done) begin
          w_state_nxt = DATA;
          w_idx_nxt   = 3'd0;
          w_txd_nxt   = r_shift[0];
        end
      end
      DATA: begin
        if (w_bit_done) begin
          if (r_idx == c_last_idx) begin
`ifdef UART_TX_PARITY_EN
            w_state_nxt = PARITY;
            w_txd_nxt   = r_parity;
`else
            w_state_nxt = STOP;
            w_txd_nxt   = 1'b1;
`endif
          end else begin
            w_shift_nxt = r_shift >> 1;
            w_idx_nxt   = r_idx + 3'd1;
            w_txd_nxt   = r_shift[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_bit_done) begin
          w_state_nxt = STOP;
          w_txd_nxt   = 1'b1;
        end
      end
`endif
      STOP: begin
        if (w_bit_done) begin
          if (w_level_nz) begin
            w_pop       = 1'b1;
            w_restart   = 1'b1;
            w_shift_nxt = w_head;
            w_state_nxt = START;
            w_txd_nxt   = 1'b0;
`ifdef UART_TX_PARITY_EN
            w_parity_nxt = ^w_head;
`endif
          end else begin
            w_state_nxt = IDLE;
            w_txd_nxt   = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_txd_nxt   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_idx   <= '0;
      r_txd   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_idx   <= w_idx_nxt;
      r_txd   <= w_txd_nxt;
`ifdef UART_TX_PARITY_EN
      r_parity <= w_parity_nxt;
`endif
    end
  end

  assign busy     = (r_state != IDLE) || w_level_nz;
  assign level    = r_level;
  assign overflow = r_overflow;
  assign TXD      = r_txd;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// +--------------------------------------------------------------------+
// | tb_uart_tx_fifo : directed and random pushes against a frame-level  |
// |   line model; every cycle compares TXD, level, busy, ready, overflow.|
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_uart_tx_fifo;

  localparam int CLK_FREQ_HZ = 40;
  localparam int BAUD_RATE   = 10;
  localparam int FIFO_DEPTH  = 4;
  localparam int CPB         = CLK_FREQ_HZ / BAUD_RATE;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CYC = NBITS * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       busy;
  logic [2:0] level;
  logic       overflow;
  logic       TXD;

  int n_checks = 0;
  int n_pass   = 0;

  // Line model: queued bytes, and position inside the frame on the wire.
  logic [7:0] m_q[$];
  bit         m_active;
  int         m_pos;
  logic [7:0] m_cur;
  bit         m_ovf;

  uart_tx_fifo #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ),
    .BAUD_RATE  (BAUD_RATE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_valid(wr_valid),
    .wr_data (wr_data),
    .wr_ready(wr_ready),
    .busy    (busy),
    .level   (level),
    .overflow(overflow),
    .TXD     (TXD)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic frame_bit(input int k, input logic [7:0] b);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic model_edge();
    int pre;
    if (reset) begin
      m_q.delete();
      m_active = 1'b0;
      m_pos    = 0;
      m_ovf    = 1'b0;
    end else begin
      pre = m_q.size();
      if (!m_active) begin
        if (pre != 0) begin
          m_cur    = m_q.pop_front();
          m_active = 1'b1;
          m_pos    = 0;
        end
      end else if (m_pos == FRAME_CYC - 1) begin
        if (pre != 0) begin
          m_cur = m_q.pop_front();
          m_pos = 0;
        end else begin
          m_active = 1'b0;
        end
      end else begin
        m_pos++;
      end
      if (wr_valid) begin
        if (pre < FIFO_DEPTH) m_q.push_back(wr_data);
        else m_ovf = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    logic exp_txd;
    exp_txd = m_active ? frame_bit(m_pos / CPB, m_cur) : 1'b1;
    check_eq("txd",      32'(TXD),      32'(exp_txd));
    check_eq("level",    32'(level),    32'(m_q.size()));
    check_eq("busy",     32'(busy),     32'(m_active || (m_q.size() != 0)));
    check_eq("wr_ready", 32'(wr_ready), 32'(m_q.size() < FIFO_DEPTH));
    check_eq("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic push_burst(input int n, input logic [7:0] first);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_data  = first + 8'(i * 37);
      step();
    end
    wr_valid = 1'b0;
    wr_data  = $urandom_range(0, 255);
  endtask

  initial begin
    reset    = 1'b1;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    m_active = 1'b0;
    m_pos    = 0;
    m_cur    = 8'h00;
    m_ovf    = 1'b0;
    repeat (2) step();
    reset = 1'b0;

    // Single 0x55 frame, then full drain
    wr_valid = 1'b1; wr_data = 8'h55; step();
    wr_valid = 1'b0; wr_data = 8'hAA;
    repeat (FRAME_CYC + 6) step();

    // Three back-to-back bytes: frames must abut
    wr_valid = 1'b1; wr_data = 8'hA3; step();
    wr_data = 8'h0F; step();
    wr_data = 8'hFF; step();
    wr_valid = 1'b0;
    repeat (3 * FRAME_CYC + 6) step();

    // Six consecutive pushes into depth 4 overflow; overflow stays set
    push_burst(6, 8'h11);
    repeat (5 * FRAME_CYC + 6) step();

    // Reset mid-frame with two bytes queued
    reset = 1'b1; step(); reset = 1'b0;
    wr_valid = 1'b1; wr_data = 8'h3C; step();
    wr_data = 8'h81; step();
    wr_data = 8'h42; step();
    wr_valid = 1'b0;
    repeat (17) step();
    reset = 1'b1; step(); reset = 1'b0;
    repeat (FRAME_CYC + 4) step();

    // All-zero byte
    wr_valid = 1'b1; wr_data = 8'h00; step();
    wr_valid = 1'b0; wr_data = 8'hFF;
    repeat (FRAME_CYC + 4) step();

    // Random traffic with varying load, occasional resets, data churn
    for (int blk = 0; blk < 12; blk++) begin
      int pct;
      pct = $urandom_range(2, 60);
      for (int c = 0; c < 250; c++) begin
        reset    = ($urandom_range(0, 399) == 0);
        wr_valid = ($urandom_range(0, 99) < pct);
        wr_data  = 8'($urandom_range(0, 255));
        step();
      end
    end
    reset    = 1'b0;
    wr_valid = 1'b0;
    repeat (6 * FRAME_CYC) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
